mem_lsu: RTL
============

// Module: mem_lsu
// PURPOSE
// Parametrised load/store unit for the MEM stage. It sits between EXE and WB
// and replaces the single-cycle dummy data-memory hookup with a req/gnt/rvalid
// bus to a variable-latency data memory. It supports byte, half and word (and
// dword when XLEN=64) accesses, with byte enables, load sign/zero extension,
// misalignment detection and a stall (ready_o) back to EXE.
// PARAMETERS
// XLEN    32  data width; legal values 32 or 64; NB = XLEN/8 byte lanes
// ADDR_W  32  address width
// TAG_W   8   width of opaque instruction tag passed EXE->WB
// PORTS
// clk_i          in   1       clock; all state changes on rising edge
// rst_i          in   1       synchronous reset, active high
// valid_i        in   1       EXE presents an instruction
// ready_o        out  1       LSU can accept; transfer when valid_i&ready_o
// is_load_i      in   1       load instruction
// is_store_i     in   1       store instruction (never both with is_load_i)
// size_i         in   2       00 B, 01 H, 10 W, 11 D
// unsigned_i     in   1       load zero-extends (LBU/LHU/LWU)
// addr_i         in   ADDR_W  ALU result: effective address, or result for non-mem ops
// wdata_i        in   XLEN    store data (rs2)
// tag_i          in   TAG_W   instruction tag
// valid_o        out  1       one-cycle pulse: result for WB
// result_o       out  XLEN    ALU pass-through or extended load data
// tag_o          out  TAG_W   tag of completing instruction
// misaligned_o   out  1       qualifies valid_o: access was misaligned or illegal
// dmem_req_o     out  1       memory request
// dmem_we_o      out  1       1 = write
// dmem_addr_o    out  ADDR_W  address, aligned down to NB bytes
// dmem_be_o      out  NB      byte enables
// dmem_wdata_o   out  XLEN    store data shifted to its byte lanes
// dmem_gnt_i     in   1       request accepted this cycle
// dmem_rvalid_i  in   1       read data valid (loads only, >=1 cycle after gnt)
// dmem_rdata_i   in   XLEN    read data, full aligned word
// BEHAVIOUR
// - Reset: state IDLE; ready_o=1, valid_o=0, misaligned_o=0, dmem_req_o=0,
//   dmem_we_o=0, result_o/tag_o/dmem_addr_o/dmem_be_o/dmem_wdata_o = 0.
//   Reset mid-transaction drops the request with no completion. A
//   dmem_rvalid_i arriving after reset is ignored.
// - FSM: IDLE, REQ, WAIT. ready_o = (state==IDLE).
// - IDLE, accept of a non-memory op: latch addr_i as result; valid_o=1 next cycle.
// - IDLE, accept of a memory op:
//   - off = addr_i[log2(NB)-1:0]. Misaligned if H and off[0]!=0, W and
//     off[1:0]!=0, or D and off[2:0]!=0. Size D with XLEN=32 is illegal.
//   - Misaligned or illegal: no bus request. Next cycle valid_o=1,
//     misaligned_o=1, result_o=0, state stays IDLE.
//   - Otherwise register addr/be/wdata/we/size/unsigned/off/tag and go to REQ.
// - REQ: dmem_req_o=1; all dmem_* outputs are held stable until dmem_gnt_i.
//   - On gnt, store: valid_o=1 next cycle, result_o=0, go to IDLE.
//   - On gnt, load: go to WAIT.
// - WAIT: dmem_req_o=0. On dmem_rvalid_i, extract (rdata >> 8*off), mask to
//   size, sign-extend unless unsigned_i. valid_o=1 next cycle, go to IDLE.
//   rvalid in the same cycle as gnt is not legal and is ignored.
// - dmem_be_o = ((1<<bytes)-1) << off, where bytes = 1/2/4/8.
//   dmem_wdata_o = wdata_i << 8*off.
// - valid_o and misaligned_o are single-cycle pulses; WB never back-pressures.
// - Latency: ALU op 1 cycle. Store 2+g cycles. Load 3+g+r cycles, where g =
//   gnt wait cycles and r = rvalid wait cycles after the WAIT entry cycle.
//   Next accept is possible in the cycle valid_o is high.
// - Only one outstanding transaction; no merging or forwarding.
// TESTING
// - ALU op addr_i=0x1234, tag 5 -> next cycle valid_o=1, result_o=0x1234, tag_o=5, no dmem_req_o.
// - SB addr=0x103, wdata=0xAB, gnt immediate -> dmem_addr_o=0x100,
//   be=4'b1000, wdata=0xAB000000; valid_o 2 cycles after accept.
// - LB addr=0x102, rdata=0x00800000, gnt after 3 cycles, rvalid after 2 more
//   -> result_o=0xFFFFFF80; LBU same -> 0x00000080; ready_o low throughout.
// - LW addr=0x102 -> no req; next cycle valid_o=1, misaligned_o=1.
//   LH addr=0x102 rdata=0xBEEF0000 -> 0xFFFFBEEF.
// - Assert rst_i while in WAIT, then pulse rvalid -> no valid_o; state IDLE; ready_o=1.
// - Back-to-back SW, LW, ALU with gnt/rvalid 0-cycle -> three valid_o pulses in order, correct tags.

Source files
------------

// File: rtl/mem_lsu.sv
// ============================================================================
// Module      : mem_lsu
// Description : MEM-stage load/store unit. Accepts one instruction at a time
//               from EXE. It passes ALU results straight through to WB.
//               Memory operations go out over a req/gnt/rvalid data-memory
//               bus. The unit computes byte enables and lane-shifted store
//               data, and extends load data with or without sign.
//               Misaligned accesses, and dword accesses on a 32-bit build,
//               complete at once with misaligned_o set and make no bus
//               request.
// Ports       : clk_i, rst_i (sync, active high)
//               EXE side : valid_i/ready_o handshake, is_load_i, is_store_i,
//                          size_i, unsigned_i, addr_i, wdata_i, tag_i
//               WB side  : valid_o (pulse), result_o, tag_o, misaligned_o
//               DMEM side: dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o,
//                          dmem_wdata_o, dmem_gnt_i, dmem_rvalid_i,
//                          dmem_rdata_i
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lsu #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic                is_load_i,
    input  logic                is_store_i,
    input  logic [1:0]          size_i,
    input  logic                unsigned_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [XLEN-1:0]     wdata_i,
    input  logic [TAG_W-1:0]    tag_i,
    output logic                valid_o,
    output logic [XLEN-1:0]     result_o,
    output logic [TAG_W-1:0]    tag_o,
    output logic                misaligned_o,
    output logic                dmem_req_o,
    output logic                dmem_we_o,
    output logic [ADDR_W-1:0]   dmem_addr_o,
    output logic [XLEN/8-1:0]   dmem_be_o,
    output logic [XLEN-1:0]     dmem_wdata_o,
    input  logic                dmem_gnt_i,
    input  logic                dmem_rvalid_i,
    input  logic [XLEN-1:0]     dmem_rdata_i
);

    localparam int         c_NB    = XLEN / 8;
    localparam int         c_OFF_W = $clog2(c_NB);
    localparam bit         c_HAS_D = (XLEN == 64);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;

    logic [1:0]          r_state;
    logic                r_valid;
    logic                r_mis;
    logic [XLEN-1:0]     r_result;
    logic [TAG_W-1:0]    r_tag_out;
    logic [TAG_W-1:0]    r_tag_pend;
    logic                r_req;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_NB-1:0]     r_be;
    logic [XLEN-1:0]     r_wdata;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [c_OFF_W-1:0]  r_off;

    // ---------------------------------------------------------------
    // Request decode (IDLE side)
    // ---------------------------------------------------------------
    logic                w_accept;
    logic                w_is_mem;
    logic [c_OFF_W-1:0]  w_off;
    logic [c_OFF_W-1:0]  w_align_mask;
    logic                w_illegal;
    logic                w_misaligned;
    logic [c_NB-1:0]     w_be_base;
    logic [c_NB-1:0]     w_be;
    logic [XLEN-1:0]     w_wdata;
    logic [ADDR_W-1:0]   w_addr_aligned;

    assign ready_o  = (r_state == c_ST_IDLE);
    assign w_accept = valid_i & ready_o;
    assign w_is_mem = is_load_i | is_store_i;
    assign w_off    = addr_i[c_OFF_W-1:0];

    // Low offset bits that must be zero for a naturally aligned access.
    // A bit mask is used instead of a modulo so that one expression covers every size.
    always_comb begin
        w_align_mask = '0;
        w_be_base    = '0;
        case (size_i)
            2'b00: begin
                w_align_mask = '0;
                w_be_base    = c_NB'(1);
            end
            2'b01: begin
                w_align_mask = c_OFF_W'(1);
                w_be_base    = c_NB'(3);
            end
            2'b10: begin
                w_align_mask = c_OFF_W'(3);
                w_be_base    = c_NB'(15);
            end
            default: begin
                w_align_mask = c_OFF_W'(7);
                w_be_base    = '1;
            end
        endcase
    end

    assign w_illegal      = (size_i == 2'b11) && !c_HAS_D;
    assign w_misaligned   = w_illegal || ((w_off & w_align_mask) != '0);
    assign w_be           = w_be_base << w_off;
    assign w_wdata        = wdata_i << {w_off, 3'b000};
    assign w_addr_aligned = {addr_i[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}};

    // ---------------------------------------------------------------
    // Load data extraction: move the addressed lane down to bit 0.
    // Shift it left so the access's MSB sits at XLEN-1. Shift back
    // right, logically or arithmetically, to zero- or sign-extend.
    // ---------------------------------------------------------------
    logic [XLEN-1:0]        w_rshift;
    logic [6:0]             w_ext_sh;
    logic [XLEN-1:0]        w_left;
    logic signed [XLEN-1:0] w_sext;
    logic [XLEN-1:0]        w_load;

    assign w_rshift = dmem_rdata_i >> {r_off, 3'b000};

    always_comb begin
        w_ext_sh = 7'd0;
        case (r_size)
            2'b00:   w_ext_sh = 7'(XLEN - 8);
            2'b01:   w_ext_sh = 7'(XLEN - 16);
            2'b10:   w_ext_sh = 7'(XLEN - 32);
            default: w_ext_sh = 7'd0;
        endcase
    end

    assign w_left = w_rshift << w_ext_sh;
    assign w_sext = $signed(w_left) >>> w_ext_sh;
    assign w_load = r_unsigned ? (w_left >> w_ext_sh) : $unsigned(w_sext);

    // ---------------------------------------------------------------
    // Control FSM and registered outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_ST_IDLE;
            r_valid    <= 1'b0;
            r_mis      <= 1'b0;
            r_result   <= '0;
            r_tag_out  <= '0;
            r_tag_pend <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_off      <= '0;
        end else begin
            r_valid <= 1'b0;
            r_mis   <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (!w_is_mem) begin
                            r_valid   <= 1'b1;
                            r_result  <= XLEN'(addr_i);
                            r_tag_out <= tag_i;
                        end else if (w_misaligned) begin
                            r_valid   <= 1'b1;
                            r_mis     <= 1'b1;
                            r_result  <= '0;
                            r_tag_out <= tag_i;
                        end else begin
                            r_req      <= 1'b1;
                            r_we       <= is_store_i;
                            r_addr     <= w_addr_aligned;
                            r_be       <= w_be;
                            r_wdata    <= w_wdata;
                            r_size     <= size_i;
                            r_unsigned <= unsigned_i;
                            r_off      <= w_off;
                            r_tag_pend <= tag_i;
                            r_state    <= c_ST_REQ;
                        end
                    end
                end
                c_ST_REQ: begin
                    if (dmem_gnt_i) begin
                        r_req <= 1'b0;
                        if (r_we) begin
                            r_valid   <= 1'b1;
                            r_result  <= '0;
                            r_tag_out <= r_tag_pend;
                            r_state   <= c_ST_IDLE;
                        end else begin
                            r_state <= c_ST_WAIT;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (dmem_rvalid_i) begin
                        r_valid   <= 1'b1;
                        r_result  <= w_load;
                        r_tag_out <= r_tag_pend;
                        r_state   <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign valid_o      = r_valid;
    assign misaligned_o = r_mis;
    assign result_o     = r_result;
    assign tag_o        = r_tag_out;
    assign dmem_req_o   = r_req;
    assign dmem_we_o    = r_we;
    assign dmem_addr_o  = r_addr;
    assign dmem_be_o    = r_be;
    assign dmem_wdata_o = r_wdata;

endmodule

`default_nettype wire
